// File: rtl/accel_pkg.sv
// Shared constants, frame FSM encoding and frame character formatting for the accelerometer UART reporter.
// Pure combinational helpers; no state, no backpressure.
package accel_pkg;

  localparam int FRAME_CHARS = 13;

  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_0     = 8'h30;
  localparam logic [7:0] CH_A     = 8'h41;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } frameState_t;

  function automatic logic [7:0] hexAscii(input logic [3:0] nib);
    if (nib < 4'd10) return CH_0 + {4'h0, nib};
    else             return CH_A + {4'h0, nib} - 8'd10;
  endfunction

  // Character idx of "hhh hhh hhh\r\n"; each 10-bit axis is shown as 12 bits, MSB nibble first.
  function automatic logic [7:0] frameChar(input logic [3:0] idx, input logic [9:0] x,
                                           input logic [9:0] y, input logic [9:0] z);
    case (idx)
      4'd0:    return hexAscii({2'b00, x[9:8]});
      4'd1:    return hexAscii(x[7:4]);
      4'd2:    return hexAscii(x[3:0]);
      4'd3:    return CH_SPACE;
      4'd4:    return hexAscii({2'b00, y[9:8]});
      4'd5:    return hexAscii(y[7:4]);
      4'd6:    return hexAscii(y[3:0]);
      4'd7:    return CH_SPACE;
      4'd8:    return hexAscii({2'b00, z[9:8]});
      4'd9:    return hexAscii(z[7:4]);
      4'd10:   return hexAscii(z[3:0]);
      4'd11:   return CH_CR;
      default: return CH_LF;
    endcase
  endfunction

endpackage

// File: rtl/accel_uart_reporter_tx.sv
// 8N1 byte shifter: a byte accepted in cycle N drives its start bit from N+1, each bit CLKS_PER_BIT cycles.
// Accepts a new byte when idle or in the last stop-bit cycle (next_req), giving gapless back-to-back bytes.
module uart_byte_tx #(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       TXD,
  output logic       busy,
  output logic       next_req
);

  localparam int BIT_W = $clog2(CLKS_PER_BIT);

  logic [BIT_W-1:0] clkCnt;
  logic [3:0]       bitIdx;
  logic [8:0]       shifter;
  logic             bitEnd;

  assign bitEnd   = busy && (clkCnt == BIT_W'(CLKS_PER_BIT - 1));
  assign next_req = bitEnd && (bitIdx == 4'd9);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      TXD     <= 1'b1;
      busy    <= 1'b0;
      clkCnt  <= '0;
      bitIdx  <= '0;
      shifter <= '1;
    end else if (valid && (!busy || next_req)) begin
      // shifter holds the bits still to go after the start bit: data LSB first, then stop
      shifter <= {1'b1, data};
      TXD     <= 1'b0;
      busy    <= 1'b1;
      clkCnt  <= '0;
      bitIdx  <= '0;
    end else if (busy) begin
      if (bitEnd) begin
        clkCnt <= '0;
        if (bitIdx == 4'd9) begin
          busy <= 1'b0;
          TXD  <= 1'b1;
        end else begin
          bitIdx  <= bitIdx + 4'd1;
          TXD     <= shifter[0];
          shifter <= {1'b1, shifter[8:1]};
        end
      end else begin
        clkCnt <= clkCnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/accel_uart_reporter.sv
// Periodically snapshots the three axes and streams them as "hhh hhh hhh\r\n" over 8N1 UART.
// Start bit follows the report tick by one cycle; ticks arriving while a frame is in flight are dropped.
module accel_uart_reporter
  import accel_pkg::*;
#(
  parameter int CLKS_PER_BIT  = 104,
  parameter int REPORT_CYCLES = 1200000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       ENABLE,
  input  logic [9:0] xAxis,
  input  logic [9:0] yAxis,
  input  logic [9:0] zAxis,
  output logic       TXD,
  output logic       BUSY,
  output logic       FRAME_DONE
);

  localparam int         CNT_W    = $clog2(REPORT_CYCLES);
  localparam logic [3:0] LAST_IDX = 4'(FRAME_CHARS - 1);

  logic [CNT_W-1:0] reportCnt;
  logic             tick;

  frameState_t state;
  logic [3:0]  idx;
  logic [9:0]  snapX, snapY, snapZ;
  logic [7:0]  nextChr;

  logic       txValid;
  logic [7:0] txData;
  logic       txNextReq;
  logic       txBusy;

  assign tick = ENABLE && (reportCnt == CNT_W'(REPORT_CYCLES - 1));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                             reportCnt <= '0;
    else if (!ENABLE)                    reportCnt <= '0;
    else if (reportCnt == CNT_W'(REPORT_CYCLES - 1)) reportCnt <= '0;
    else                                 reportCnt <= reportCnt + 1'b1;
  end

  // The first character comes straight from the live inputs so its start bit can follow the tick
  // immediately; the same edge captures those inputs into the snapshot for the remaining characters.
  assign txData  = (state == IDLE) ? frameChar(4'd0, xAxis, yAxis, zAxis) : nextChr;
  assign txValid = ((state == IDLE) && tick) ||
                   ((state == SEND) && txNextReq && (idx != LAST_IDX));

  // idx is the character on the wire; LOAD prefetches character idx+1 so it is ready at next_req.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      idx        <= '0;
      snapX      <= '0;
      snapY      <= '0;
      snapZ      <= '0;
      nextChr    <= '0;
      FRAME_DONE <= 1'b0;
    end else begin
      FRAME_DONE <= 1'b0;
      case (state)
        IDLE: begin
          if (tick) begin
            snapX <= xAxis;
            snapY <= yAxis;
            snapZ <= zAxis;
            idx   <= '0;
            state <= LOAD;
          end
        end
        LOAD: begin
          nextChr <= frameChar(idx + 4'd1, snapX, snapY, snapZ);
          state   <= SEND;
        end
        SEND: begin
          if (txNextReq) begin
            if (idx == LAST_IDX) begin
              state      <= DONE;
              FRAME_DONE <= 1'b1;
            end else begin
              idx   <= idx + 4'd1;
              state <= LOAD;
            end
          end
        end
        DONE: begin
          idx   <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Bytes run back to back, so the shifter's busy spans exactly the frame.
  assign BUSY = txBusy;

  uart_byte_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) uByteTx (
    .CLK     (CLK),
    .RST     (RST),
    .data    (txData),
    .valid   (txValid),
    .TXD     (TXD),
    .busy    (txBusy),
    .next_req(txNextReq)
  );

endmodule

// File: tb/tb_accel_uart_reporter.sv
// Directed bench for accel_uart_reporter: table of axis vectors with expected ASCII frames, plus
// hand-written sequences for enable drop, mid-frame reset and dropped ticks.
module tb_accel_uart_reporter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstA, enA, rstB, enB;
  logic [9:0] xAx, yAx, zAx;
  logic       txdA, busyA, doneA, txdB, busyB, doneB;
  logic       sel;
  logic       txdM, busyM, doneM;

  assign txdM  = sel ? txdB  : txdA;
  assign busyM = sel ? busyB : busyA;
  assign doneM = sel ? doneB : doneA;

  accel_uart_reporter #(.CLKS_PER_BIT(4), .REPORT_CYCLES(1000)) dutA (
    .CLK(clk), .RST(rstA), .ENABLE(enA), .xAxis(xAx), .yAxis(yAx), .zAxis(zAx),
    .TXD(txdA), .BUSY(busyA), .FRAME_DONE(doneA)
  );

  accel_uart_reporter #(.CLKS_PER_BIT(4), .REPORT_CYCLES(300)) dutB (
    .CLK(clk), .RST(rstB), .ENABLE(enB), .xAxis(xAx), .yAxis(yAx), .zAxis(zAx),
    .TXD(txdB), .BUSY(busyB), .FRAME_DONE(doneB)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [9:0]   x;
    logic [9:0]   y;
    logic [9:0]   z;
    bit           midChange;
    logic [103:0] exp;
  } vec_t;

  vec_t vecs [3];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic waitStart(input int budget, output bit found, output int atCyc);
    found = 0;
    atCyc = 0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clk);
      if (txdM === 1'b0) begin
        found = 1;
        atCyc = cyc;
      end
    end
  endtask

  // Called at the first start-bit sample; decodes 13 chars over 520 cycles, then the done cycle.
  task automatic readFrame(input string tag, input logic [103:0] exp);
    int         busyCnt, badBits, doneIn, r, b, c;
    logic [9:0] bv;
    busyCnt = 0;
    badBits = 0;
    doneIn  = 0;
    bv      = '0;
    for (int k = 0; k < 520; k++) begin
      if (k > 0) @(negedge clk);
      r = k % 40;
      b = r / 4;
      c = k / 40;
      if (r % 4 == 0) bv[b] = txdM;
      else if (txdM !== bv[b]) badBits++;
      if (busyM === 1'b1) busyCnt++;
      if (doneM === 1'b1) doneIn++;
      if (r == 39) begin
        if (bv[0] !== 1'b0 || bv[9] !== 1'b1) badBits++;
        check($sformatf("%s char%0d", tag, c), {24'h0, bv[8:1]}, {24'h0, exp[(12 - c) * 8 +: 8]});
      end
    end
    check({tag, " framing"}, badBits, 0);
    check({tag, " busy cycles"}, busyCnt, 520);
    check({tag, " done inside frame"}, doneIn, 0);
    @(negedge clk);
    check({tag, " done pulse"}, doneM, 1);
    check({tag, " busy after frame"}, busyM, 0);
    check({tag, " txd after frame"}, txdM, 1);
    @(negedge clk);
    check({tag, " done one cycle"}, doneM, 0);
  endtask

  initial begin
    bit found;
    int st, prevStart, rel, idleBad;

    vecs[0] = '{10'h3FF, 10'h000, 10'h2A5, 1'b1,
                {8'h33, 8'h46, 8'h46, 8'h20, 8'h30, 8'h30, 8'h30, 8'h20, 8'h32, 8'h41, 8'h35, 8'h0D, 8'h0A}};
    vecs[1] = '{10'h155, 10'h155, 10'h155, 1'b0,
                {8'h31, 8'h35, 8'h35, 8'h20, 8'h31, 8'h35, 8'h35, 8'h20, 8'h31, 8'h35, 8'h35, 8'h0D, 8'h0A}};
    vecs[2] = '{10'h09C, 10'h1E0, 10'h37B, 1'b0,
                {8'h30, 8'h39, 8'h43, 8'h20, 8'h31, 8'h45, 8'h30, 8'h20, 8'h33, 8'h37, 8'h42, 8'h0D, 8'h0A}};

    sel  = 1'b0;
    rstA = 1'b1;
    rstB = 1'b1;
    enA  = 1'b0;
    enB  = 1'b0;
    xAx  = '0;
    yAx  = '0;
    zAx  = '0;

    repeat (5) @(negedge clk);
    check("reset TXD", txdA, 1);
    check("reset BUSY", busyA, 0);
    check("reset FRAME_DONE", doneA, 0);
    rstA = 1'b0;

    idleBad = 0;
    repeat (1000) begin
      @(negedge clk);
      if (txdA !== 1'b1 || busyA !== 1'b0) idleBad++;
    end
    check("idle while disabled", idleBad, 0);

    enA = 1'b1;
    prevStart = 0;
    for (int i = 0; i < 3; i++) begin
      xAx = vecs[i].x;
      yAx = vecs[i].y;
      zAx = vecs[i].z;
      waitStart(1100, found, st);
      check($sformatf("vec%0d start found", i), found, 1);
      if (i > 0) check($sformatf("vec%0d frame period", i), st - prevStart, 1000);
      prevStart = st;
      if (vecs[i].midChange) begin
        fork
          begin
            repeat (260) @(negedge clk);
            xAx = 10'h155;
            yAx = 10'h155;
            zAx = 10'h155;
          end
        join_none
      end
      readFrame($sformatf("vec%0d", i), vecs[i].exp);
    end

    // ENABLE drops during character 5: frame finishes, nothing follows
    waitStart(1100, found, st);
    check("endis start found", found, 1);
    check("endis frame period", st - prevStart, 1000);
    fork
      begin
        repeat (5 * 40 + 2) @(negedge clk);
        enA = 1'b0;
      end
    join_none
    readFrame("endis", vecs[2].exp);
    waitStart(2100, found, st);
    check("no start after disable", found, 0);

    // Reset during character 7 start bit
    enA = 1'b1;
    waitStart(1100, found, st);
    check("rst start found", found, 1);
    repeat (7 * 40 + 2) @(negedge clk);
    check("char7 start bit before reset", txdA, 0);
    #2 rstA = 1'b1;
    #1;
    check("async reset TXD", txdA, 1);
    check("async reset BUSY", busyA, 0);
    repeat (3) @(negedge clk);
    check("held reset TXD", txdA, 1);
    rstA = 1'b0;
    rel  = cyc;
    waitStart(1100, found, st);
    check("post-reset start found", found, 1);
    check("post-reset start delay", st - rel, 1000);
    readFrame("postrst", vecs[2].exp);

    // Short report period: every other tick is dropped
    sel = 1'b1;
    @(negedge clk);
    rstB = 1'b0;
    enB  = 1'b1;
    rel  = cyc;
    waitStart(400, found, st);
    check("drop frame0 found", found, 1);
    check("drop frame0 start", st - rel, 300);
    readFrame("drop0", vecs[2].exp);
    prevStart = st;
    for (int j = 1; j < 3; j++) begin
      waitStart(700, found, st);
      check($sformatf("drop frame%0d found", j), found, 1);
      check($sformatf("drop frame%0d period", j), st - prevStart, 600);
      readFrame($sformatf("drop%0d", j), vecs[2].exp);
      prevStart = st;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
